// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller and its helpers.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FCNT_W     = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Signal bundle between the pipeline stages and hazard_controller.
// Perf counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_controller_if;
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic                  id_rs1_used_i;
    logic                  id_rs2_used_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic                  ex_mem_read_i;
    logic                  mispredict_i;
    logic                  dmem_req_i;
    logic                  dmem_ready_i;
    logic                  stall_if_o;
    logic                  buble_o;
    logic                  flush_if_o;
    logic                  flush_id_o;
    logic [1:0]            state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]           stall_cnt_o;
    logic [31:0]           flush_cnt_o;
`endif

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_i, ex_mem_read_i, mispredict_i, dmem_req_i, dmem_ready_i,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cnt_o, flush_cnt_o,
`endif
        input  stall_if_o, buble_o, flush_if_o, flush_id_o, state_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_i, ex_mem_read_i, mispredict_i, dmem_req_i, dmem_ready_i,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cnt_o, flush_cnt_o,
`endif
        output stall_if_o, buble_o, flush_if_o, flush_id_o, state_o
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID source registers and the EX load target.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stalls, multi-cycle mispredict flush, memory freeze.
// Optional HAZARD_PERF_CNT_EN adds stall/flush event counters.
//
// state    | meaning
// ---------+---------------------------------------------
// RUN      | normal flow, load-use stalls handled inline
// FLUSH    | counting down remaining flush cycles (fcnt)
// MEM_WAIT | pipe frozen on an outstanding data access
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int FLUSH_DEPTH = 1
) (
    input  logic          clk,
    input  logic          reset,
    hazard_controller_if.slave hz
);

    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_FLUSH    = FLUSH;
    localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;

    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_DEPTH - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_nxt;
    logic              pend_flush;
    logic              pend_nxt;

    logic              load_use;
    logic              mw;
    logic              mp_eff;
    logic              mp_apply;
    logic              stall_c;
    logic              buble_c;
    logic              flush_if_c;
    logic              flush_id_c;

    load_use_detect u_load_use_detect (
        .id_rs1      (hz.id_rs1_i),
        .id_rs2      (hz.id_rs2_i),
        .id_rs1_used (hz.id_rs1_used_i),
        .id_rs2_used (hz.id_rs2_used_i),
        .ex_rd       (hz.ex_rd_i),
        .ex_mem_read (hz.ex_mem_read_i),
        .hazard      (load_use)
    );

    assign mw     = hz.dmem_req_i & ~hz.dmem_ready_i;
    // pend_flush is only ever set while frozen, so it applies exactly on the exit cycle
    assign mp_eff = hz.mispredict_i | pend_flush;

    // A nonzero fcnt means flush cycles remain, whether we are in FLUSH or were
    // interrupted into MEM_WAIT; the exit cycle from MEM_WAIT is itself a flush cycle.
    always_comb begin
        state_nxt  = state;
        fcnt_nxt   = fcnt;
        pend_nxt   = pend_flush;
        mp_apply   = 1'b0;
        stall_c    = 1'b0;
        buble_c    = 1'b0;
        flush_if_c = 1'b0;
        flush_id_c = 1'b0;

        if (mw) begin
            stall_c   = 1'b1;
            buble_c   = 1'b1;
            state_nxt = ST_MEM_WAIT;
            if (hz.mispredict_i) begin
                pend_nxt = 1'b1;
            end
        end else begin
            pend_nxt = 1'b0;
            if (mp_eff) begin
                flush_if_c = 1'b1;
                flush_id_c = 1'b1;
                fcnt_nxt   = FCNT_RELOAD;
                mp_apply   = 1'b1;
            end else if (fcnt != '0) begin
                flush_if_c = 1'b1;
                flush_id_c = 1'b1;
                fcnt_nxt   = fcnt - FCNT_W'(1);
            end else if (load_use && (state != ST_FLUSH)) begin
                stall_c    = 1'b1;
                flush_id_c = 1'b1;
            end
            state_nxt = (fcnt_nxt != '0) ? ST_FLUSH : ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            fcnt       <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            fcnt       <= fcnt_nxt;
            pend_flush <= pend_nxt;
        end
    end

    // Outputs are forced low for the whole reset window, not just after the edge
    assign hz.stall_if_o = stall_c    & ~reset;
    assign hz.buble_o    = buble_c    & ~reset;
    assign hz.flush_if_o = flush_if_c & ~reset;
    assign hz.flush_id_o = flush_id_c & ~reset;
    assign hz.state_o    = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_c) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (mp_apply) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign hz.stall_cnt_o = stall_cnt;
    assign hz.flush_cnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller with FLUSH_DEPTH=3.
module tb_hazard_controller;
    import hazard_pkg::*;

    localparam int FD = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    hazard_controller_if hz();

    hazard_controller #(.FLUSH_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    // {stall_if, buble, flush_if, flush_id, state[1:0]}
    function automatic logic [5:0] outs();
        return {hz.stall_if_o, hz.buble_o, hz.flush_if_o, hz.flush_id_o, hz.state_o};
    endfunction

    task automatic clear_inputs();
        hz.id_rs1_i      = '0;
        hz.id_rs2_i      = '0;
        hz.id_rs1_used_i = 1'b0;
        hz.id_rs2_used_i = 1'b0;
        hz.ex_rd_i       = '0;
        hz.ex_mem_read_i = 1'b0;
        hz.mispredict_i  = 1'b0;
        hz.dmem_req_i    = 1'b0;
        hz.dmem_ready_i  = 1'b0;
    endtask

    task automatic set_rs1_load_use();
        hz.id_rs1_i      = 5'd5;
        hz.id_rs1_used_i = 1'b1;
        hz.ex_rd_i       = 5'd5;
        hz.ex_mem_read_i = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset = 1'b1;
        set_rs1_load_use();
        hz.mispredict_i = 1'b1;
        #2;
        obs = outs();
        checks++;
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL reset_hold obs=%b exp=%b", obs, 6'b000000);
        end
        clear_inputs();
        step();
        reset = 1'b0;
        #1;
        obs = outs();
        checks++;
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL reset_release obs=%b exp=%b", obs, 6'b000000);
        end
    endtask

    task automatic test_load_use();
        // rs1, rs2, rs1_used, rs2_used, rd, mem_read, expected outputs
        logic [4:0] rs1 [6] = '{5'd5, 5'd0, 5'd1, 5'd9, 5'd5, 5'd5};
        logic [4:0] rs2 [6] = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0};
        logic       u1  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       u2  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [4:0] rd  [6] = '{5'd5, 5'd0, 5'd7, 5'd9, 5'd5, 5'd6};
        logic       mr  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [5:0] ex  [6] = '{6'b100100, 6'b000000, 6'b100100,
                                6'b000000, 6'b000000, 6'b000000};
        logic [5:0] obs;
        for (int i = 0; i < 6; i++) begin
            step();
            hz.id_rs1_i      = rs1[i];
            hz.id_rs2_i      = rs2[i];
            hz.id_rs1_used_i = u1[i];
            hz.id_rs2_used_i = u2[i];
            hz.ex_rd_i       = rd[i];
            hz.ex_mem_read_i = mr[i];
            #1;
            obs = outs();
            checks++;
            if (obs !== ex[i]) begin
                failures++;
                $display("FAIL load_use_case%0d obs=%b exp=%b", i, obs, ex[i]);
            end
            step();
            clear_inputs();
            #1;
            obs = outs();
            checks++;
            if (obs !== 6'b000000) begin
                failures++;
                $display("FAIL load_use_clear%0d obs=%b exp=%b", i, obs, 6'b000000);
            end
        end
    endtask

    task automatic test_mispredict();
        logic [5:0] ex [4] = '{6'b001100, 6'b001101, 6'b001101, 6'b000000};
        logic [5:0] obs;
        for (int c = 0; c < 4; c++) begin
            step();
            clear_inputs();
            if (c == 0) hz.mispredict_i = 1'b1;
            if (c == 1) set_rs1_load_use();
            #1;
            obs = outs();
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL mispredict_c%0d obs=%b exp=%b", c, obs, ex[c]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic       req [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       mp  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [5:0] ex  [8] = '{6'b110000, 6'b110010, 6'b110010, 6'b110010,
                                6'b001110, 6'b001101, 6'b001101, 6'b000000};
        logic [5:0] obs;
        for (int c = 0; c < 8; c++) begin
            step();
            clear_inputs();
            hz.dmem_req_i   = req[c];
            hz.dmem_ready_i = rdy[c];
            hz.mispredict_i = mp[c];
            #1;
            obs = outs();
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL mem_wait_c%0d obs=%b exp=%b", c, obs, ex[c]);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [5:0] ex [4] = '{6'b001100, 6'b001101, 6'b001101, 6'b000000};
        logic [5:0] obs;
        for (int c = 0; c < 4; c++) begin
            step();
            clear_inputs();
            if (c == 0) begin
                set_rs1_load_use();
                hz.mispredict_i = 1'b1;
            end
            #1;
            obs = outs();
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL same_cycle_c%0d obs=%b exp=%b", c, obs, ex[c]);
            end
        end
    endtask

    task automatic test_flush_interrupted();
        logic       req [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [5:0] ex  [6] = '{6'b001100, 6'b001101, 6'b110001,
                                6'b110010, 6'b001110, 6'b000000};
        logic [5:0] obs;
        for (int c = 0; c < 6; c++) begin
            step();
            clear_inputs();
            hz.mispredict_i = (c == 0);
            hz.dmem_req_i   = req[c];
            hz.dmem_ready_i = rdy[c];
            #1;
            obs = outs();
            checks++;
            if (obs !== ex[c]) begin
                failures++;
                $display("FAIL flush_interrupted_c%0d obs=%b exp=%b", c, obs, ex[c]);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [5:0] obs;
        step();
        clear_inputs();
        hz.mispredict_i = 1'b1;
        step();
        clear_inputs();
        #1;
        obs = outs();
        checks++;
        if (obs !== 6'b001101) begin
            failures++;
            $display("FAIL rst_mid_flush_pre obs=%b exp=%b", obs, 6'b001101);
        end
        #1;
        reset = 1'b1;
        #1;
        obs = outs();
        checks++;
        if (obs !== 6'b000000) begin
            failures++;
            $display("FAIL rst_mid_flush_async obs=%b exp=%b", obs, 6'b000000);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            obs = outs();
            checks++;
            if (obs !== 6'b000000) begin
                failures++;
                $display("FAIL rst_mid_flush_after%0d obs=%b exp=%b", c, obs, 6'b000000);
            end
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            set_rs1_load_use();
            step();
            clear_inputs();
        end
        for (int i = 0; i < 2; i++) begin
            step();
            hz.mispredict_i = 1'b1;
            step();
            hz.mispredict_i = 1'b0;
            step();
            step();
            step();
        end
        checks++;
        if (hz.stall_cnt_o !== 32'd3) begin
            failures++;
            $display("FAIL stall_cnt obs=%0d exp=%0d", hz.stall_cnt_o, 3);
        end
        checks++;
        if (hz.flush_cnt_o !== 32'd2) begin
            failures++;
            $display("FAIL flush_cnt obs=%0d exp=%0d", hz.flush_cnt_o, 2);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_mispredict();
        test_mem_wait();
        test_same_cycle();
        test_flush_interrupted();
        test_reset_mid_flush();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
